// File: rtl/clk_div_sched.sv
// clk_div_sched: NCH-channel clock-enable divider whose ratio updates only land on period boundaries.
// Define CLK_DIV_SCHED_LOCK_EN to build the optional o_locked output.
module clk_div_sched #(
   parameter int NCH      = 3,
   parameter int CW       = 16,
   parameter int DEF_DIV0 = 19,
   parameter int DEF_DIV1 = 359,
   parameter int DEF_DIV2 = 179
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic           run_en,
   input  logic           sync_req,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [1:0]     cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   output logic           cfg_err,
   output logic [NCH-1:0] o_ce,
   output logic [NCH-1:0] o_clk,
   output logic           busy
`ifdef CLK_DIV_SCHED_LOCK_EN
   ,
   output logic           o_locked
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ALIGN = 2'd2} state_t;

   function automatic logic [CW-1:0] def_div(input int ch);
      case (ch)
         0:       return CW'(DEF_DIV0);
         1:       return CW'(DEF_DIV1);
         2:       return CW'(DEF_DIV2);
         default: return {CW{1'b1}};
      endcase
   endfunction

   state_t         state, state_n;
   logic [CW-1:0]  cnt_p0 [NCH];
   logic [CW-1:0]  cnt_n  [NCH];
   logic [CW-1:0]  div_r  [NCH];
   logic [CW-1:0]  div_n  [NCH];
   logic [NCH-1:0] ce_n, clk_n, ce_p1, clk_p1, tgt;
   logic           pend, err_p1, accept, bad_ch, term_hit, apply;
   logic [1:0]     sh_ch;
   logic [CW-1:0]  sh_div;

   assign accept    = cfg_valid & ~pend;
   assign bad_ch    = (int'(cfg_ch) >= NCH);
   assign cfg_ready = ~pend;
   assign busy      = pend;
   assign cfg_err   = err_p1;
   assign o_ce      = ce_p1;
   assign o_clk     = clk_p1;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (run_en) state_n = RUN;
         RUN: begin
            if (!run_en)       state_n = IDLE;
            else if (sync_req) state_n = ALIGN;
         end
         ALIGN:   state_n = run_en ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      tgt      = '0;
      term_hit = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         tgt[i] = pend && (int'(sh_ch) == i);
         if (tgt[i] && (cnt_p0[i] == div_r[i])) term_hit = 1'b1;
      end
   end

   // In RUN a pending ratio waits for the target's terminal count; elsewhere it lands at once
   always_comb begin
      apply = 1'b0;
      if (pend) begin
         case (state)
            RUN:     apply = term_hit && (state_n == RUN);
            default: apply = 1'b1;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         div_n[i] = (apply && tgt[i]) ? sh_div : div_r[i];
         cnt_n[i] = '0;
         ce_n[i]  = 1'b0;
         clk_n[i] = 1'b0;
         if (state == RUN && state_n == RUN) begin
            ce_n[i]  = (cnt_p0[i] == div_r[i]);
            clk_n[i] = (cnt_p0[i] <= (div_r[i] >> 1));
            cnt_n[i] = ce_n[i] ? '0 : cnt_p0[i] + 1'b1;
         end else if (state == ALIGN && state_n == RUN) begin
            // ALIGN doubles as the count-0 cycle, so the first strobe lands div+1 after it
            ce_n[i]  = (div_n[i] == '0);
            clk_n[i] = 1'b1;
            cnt_n[i] = ce_n[i] ? '0 : CW'(1);
         end
      end
   end

   // p0 -> p1: counters, ratios and registered strobes
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state  <= IDLE;
         pend   <= 1'b0;
         err_p1 <= 1'b0;
         ce_p1  <= '0;
         clk_p1 <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_p0[i] <= '0;
            div_r[i]  <= def_div(i);
         end
      end else begin
         state  <= state_n;
         pend   <= (accept && !bad_ch) || (pend && !apply);
         err_p1 <= accept && bad_ch;
         ce_p1  <= ce_n;
         clk_p1 <= clk_n;
         for (int i = 0; i < NCH; i++) begin
            cnt_p0[i] <= cnt_n[i];
            div_r[i]  <= div_n[i];
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (accept) begin
         sh_ch  <= cfg_ch;
         sh_div <= cfg_div;
      end
   end

`ifdef CLK_DIV_SCHED_LOCK_EN
   // Lock means every channel has strobed since the last stop, align or ratio change
   logic [NCH-1:0] seen;
   logic           locked, lock_clr;

   assign lock_clr = apply || (state != RUN) || (state_n != RUN);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         seen   <= '0;
         locked <= 1'b0;
      end else if (lock_clr) begin
         seen   <= '0;
         locked <= 1'b0;
      end else begin
         seen   <= seen | ce_p1;
         locked <= &(seen | ce_p1);
      end
   end

   assign o_locked = locked;
`endif

endmodule
